// File: rtl/tlb_writer_if.sv
// tlb_writer_if: CP0-side request/response bundle for the TLB writer.
interface tlb_writer_if;
  logic                 tlbwi;
  logic                 tlbwr;
  logic                 tlbr;
  logic [2:0]           index_i;
  logic                 wired_we;
  logic [2:0]           wired_i;
  logic [18:0]          entryhi_vpn2;
  logic [7:0]           entryhi_asid;
  logic [25:0]          entrylo0_i;
  logic [25:0]          entrylo1_i;
  logic [7:0][77:0]     TLB_entries;
  logic [2:0]           random_o;
  logic [2:0]           wired_o;
  logic                 rd_valid;
  logic [18:0]          rd_vpn2;
  logic [7:0]           rd_asid;
  logic [25:0]          rd_entrylo0;
  logic [25:0]          rd_entrylo1;
  logic                 tlb_changed;
  modport master (
    output tlbwi, tlbwr, tlbr, index_i, wired_we, wired_i,
           entryhi_vpn2, entryhi_asid, entrylo0_i, entrylo1_i,
    input  TLB_entries, random_o, wired_o, rd_valid, rd_vpn2, rd_asid,
           rd_entrylo0, rd_entrylo1, tlb_changed
  );
  modport slave (
    input  tlbwi, tlbwr, tlbr, index_i, wired_we, wired_i,
           entryhi_vpn2, entryhi_asid, entrylo0_i, entrylo1_i,
    output TLB_entries, random_o, wired_o, rd_valid, rd_vpn2, rd_asid,
           rd_entrylo0, rd_entrylo1, tlb_changed
  );
endinterface

// File: rtl/tlb_writer.sv
// tlb_writer: 8-entry TLB storage with TLBWI/TLBWR/TLBR and Random/Wired upkeep.
module tlb_writer (
  input logic        clk,
  input logic        rst,
  tlb_writer_if.slave bus
);
  localparam int NENTRY = 8;
  // entry layout, MSB first: VPN2[77:59] ASID[58:51] G[50] {PFN0,C0,D0,V0}[49:25] {PFN1,C1,D1,V1}[24:0]
  logic [NENTRY-1:0][77:0] r_tlb;
  logic [77:0]             r_rd;
  logic [2:0]              r_random;
  logic [2:0]              r_wired;
  logic                    r_rd_valid;
  logic                    r_changed;
  logic                    w_we;
  logic [2:0]              w_idx;
  logic [77:0]             w_new;
  assign w_we  = bus.tlbwi | bus.tlbwr;
  assign w_idx = bus.tlbwi ? bus.index_i : r_random;
  assign w_new = {bus.entryhi_vpn2, bus.entryhi_asid, bus.entrylo0_i[0] & bus.entrylo1_i[0],
                  bus.entrylo0_i[25:1], bus.entrylo1_i[25:1]};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tlb      <= '0;
      r_rd       <= '0;
      r_random   <= 3'd7;
      r_wired    <= 3'd0;
      r_rd_valid <= 1'b0;
      r_changed  <= 1'b0;
    end else begin
      if (w_we) r_tlb[w_idx] <= w_new;
      if (bus.tlbr) r_rd <= r_tlb[bus.index_i];
      r_rd_valid <= bus.tlbr;
      r_changed  <= w_we;
      r_random   <= (bus.wired_we || r_random == r_wired) ? 3'd7 : r_random - 3'd1;
      r_wired    <= bus.wired_we ? bus.wired_i : r_wired;
    end
  end
  assign bus.TLB_entries = r_tlb;
  assign bus.random_o    = r_random;
  assign bus.wired_o     = r_wired;
  assign bus.rd_valid    = r_rd_valid;
  assign bus.rd_vpn2     = r_rd[77:59];
  assign bus.rd_asid     = r_rd[58:51];
  assign bus.rd_entrylo0 = {r_rd[49:25], r_rd[50]};
  assign bus.rd_entrylo1 = {r_rd[24:0], r_rd[50]};
  assign bus.tlb_changed = r_changed;
endmodule

// File: tb/tb_tlb_writer.sv
// tb_tlb_writer: directed plus randomized checks of tlb_writer against a field-level TLB model.
module tb_tlb_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  tlb_writer_if bus ();
  tlb_writer dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [18:0] m_vpn2 [8];
  logic [7:0]  m_asid [8];
  logic        m_g    [8];
  logic [24:0] m_pl0  [8];
  logic [24:0] m_pl1  [8];
  logic [2:0]  m_rnd, m_wired;
  logic        m_rdv, m_chg;
  logic [18:0] e_rvpn;
  logic [7:0]  e_rasid;
  logic [25:0] e_rlo0, e_rlo1;
  task automatic chk(input string tag, input logic [77:0] obs, input logic [77:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("random", 78'(bus.random_o), 78'(m_rnd));
    chk("wired", 78'(bus.wired_o), 78'(m_wired));
    chk("tlb_changed", 78'(bus.tlb_changed), 78'(m_chg));
    chk("rd_valid", 78'(bus.rd_valid), 78'(m_rdv));
    chk("rd_vpn2", 78'(bus.rd_vpn2), 78'(e_rvpn));
    chk("rd_asid", 78'(bus.rd_asid), 78'(e_rasid));
    chk("rd_lo0", 78'(bus.rd_entrylo0), 78'(e_rlo0));
    chk("rd_lo1", 78'(bus.rd_entrylo1), 78'(e_rlo1));
    for (int i = 0; i < 8; i++)
      chk($sformatf("entry%0d", i), bus.TLB_entries[i], {m_vpn2[i], m_asid[i], m_g[i], m_pl0[i], m_pl1[i]});
  endtask
  task automatic tick();
    logic [2:0] t;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_vpn2[i] = '0; m_asid[i] = '0; m_g[i] = 1'b0; m_pl0[i] = '0; m_pl1[i] = '0;
      end
      m_rnd = 3'd7; m_wired = 3'd0; m_rdv = 1'b0; m_chg = 1'b0;
      e_rvpn = '0; e_rasid = '0; e_rlo0 = '0; e_rlo1 = '0;
    end else begin
      if (bus.tlbr) begin
        e_rvpn  = m_vpn2[bus.index_i];
        e_rasid = m_asid[bus.index_i];
        e_rlo0  = {m_pl0[bus.index_i], m_g[bus.index_i]};
        e_rlo1  = {m_pl1[bus.index_i], m_g[bus.index_i]};
      end
      m_rdv = bus.tlbr;
      m_chg = bus.tlbwi | bus.tlbwr;
      if (m_chg) begin
        t = bus.tlbwi ? bus.index_i : m_rnd;
        m_vpn2[t] = bus.entryhi_vpn2;
        m_asid[t] = bus.entryhi_asid;
        m_g[t]    = bus.entrylo0_i[0] & bus.entrylo1_i[0];
        m_pl0[t]  = bus.entrylo0_i[25:1];
        m_pl1[t]  = bus.entrylo1_i[25:1];
      end
      if (bus.wired_we) begin
        m_rnd = 3'd7;
        m_wired = bus.wired_i;
      end else if (m_rnd == m_wired) m_rnd = 3'd7;
      else m_rnd = m_rnd - 3'd1;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic idle();
    bus.tlbwi = 0; bus.tlbwr = 0; bus.tlbr = 0; bus.wired_we = 0;
  endtask
  task automatic set_data(input logic [18:0] v, input logic [7:0] a, input logic [25:0] l0, input logic [25:0] l1);
    bus.entryhi_vpn2 = v; bus.entryhi_asid = a; bus.entrylo0_i = l0; bus.entrylo1_i = l1;
  endtask
  initial begin
    idle();
    bus.index_i = 0; bus.wired_i = 0;
    set_data($urandom, $urandom, $urandom, $urandom);
    bus.tlbwi = 1; bus.index_i = 3'd2;
    tick();
    tick();
    idle();
    rst = 1'b0;
    tick();
    chk("reset_random", 78'(bus.random_o), 78'd6);
    // TLBWI with mixed G bits
    bus.tlbwi = 1; bus.index_i = 3'd3;
    set_data(19'h12345, 8'h5A, {20'hABCDE, 3'd3, 1'b1, 1'b1, 1'b1}, {20'($urandom), 3'($urandom), 2'($urandom), 1'b0});
    tick();
    idle();
    chk("e3_g", 78'(bus.TLB_entries[3][50]), 78'd0);
    chk("e3_pfn0", 78'(bus.TLB_entries[3][49:30]), 78'hABCDE);
    chk("e3_c0", 78'(bus.TLB_entries[3][29:27]), 78'd3);
    chk("e3_dv0", 78'(bus.TLB_entries[3][26:25]), 78'd3);
    chk("e3_chg", 78'(bus.tlb_changed), 78'd1);
    tick();
    chk("e3_chg_end", 78'(bus.tlb_changed), 78'd0);
    // Wired=5 then free-run; TLBWR at Random=6 hits entry 6
    bus.wired_we = 1; bus.wired_i = 3'd5;
    tick();
    idle();
    chk("seq7", 78'(bus.random_o), 78'd7);
    tick();
    chk("seq6", 78'(bus.random_o), 78'd6);
    bus.tlbwr = 1;
    set_data(19'h6666, 8'h66, 26'($urandom), 26'($urandom));
    tick();
    idle();
    chk("seq5", 78'(bus.random_o), 78'd5);
    chk("e6_vpn", 78'(bus.TLB_entries[6][77:59]), 78'h6666);
    tick();
    chk("seq_wrap", 78'(bus.random_o), 78'd7);
    tick();
    chk("seq6b", 78'(bus.random_o), 78'd6);
    // tlbwi beats tlbwr
    bus.wired_we = 1; bus.wired_i = 3'd0;
    tick();
    idle();
    for (int i = 0; i < 3; i++) tick();
    chk("rnd4", 78'(bus.random_o), 78'd4);
    bus.tlbwi = 1; bus.tlbwr = 1; bus.index_i = 3'd1;
    set_data(19'h11111, 8'h11, 26'($urandom), 26'($urandom));
    tick();
    idle();
    chk("both_e1", 78'(bus.TLB_entries[1][77:59]), 78'h11111);
    chk("both_e4", bus.TLB_entries[4], 78'd0);
    // read-before-write on the same entry
    bus.tlbwi = 1; bus.index_i = 3'd2;
    set_data(19'h0AAAA, 8'hAA, 26'($urandom), 26'($urandom));
    tick();
    bus.tlbr = 1;
    set_data(19'h0BBBB, 8'hBB, 26'($urandom), 26'($urandom));
    tick();
    idle();
    chk("rbw_old", 78'(bus.rd_vpn2), 78'h0AAAA);
    tick();
    chk("rd_hold", 78'(bus.rd_vpn2), 78'h0AAAA);
    bus.tlbr = 1;
    tick();
    idle();
    chk("rbw_new", 78'(bus.rd_vpn2), 78'h0BBBB);
    // Wired=7 pins Random at 7
    bus.wired_we = 1; bus.wired_i = 3'd7;
    tick();
    idle();
    for (int i = 0; i < 3; i++) tick();
    chk("wired7", 78'(bus.random_o), 78'd7);
    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      bus.tlbwi    = ($urandom_range(0, 3) == 0);
      bus.tlbwr    = ($urandom_range(0, 3) == 0);
      bus.tlbr     = ($urandom_range(0, 2) == 0);
      bus.wired_we = ($urandom_range(0, 19) == 0);
      bus.wired_i  = 3'($urandom);
      bus.index_i  = 3'($urandom);
      set_data(19'($urandom), 8'($urandom), 26'($urandom), 26'($urandom));
      tick();
    end
    idle();
    tick();
    // reset during a write discards it
    rst = 1'b1;
    bus.tlbwi = 1; bus.index_i = 3'd4;
    set_data(19'h7FFFF, 8'hFF, 26'h3FFFFFF, 26'h3FFFFFF);
    tick();
    idle();
    chk("rst_e4", bus.TLB_entries[4], 78'd0);
    chk("rst_chg", 78'(bus.tlb_changed), 78'd0);
    chk("rst_rnd", 78'(bus.random_o), 78'd7);
    rst = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
